// File: rtl/ray_gen_stream_if.sv
// ray_gen_stream_if
//   Carries the ray output stream from the generator to a traversal core.
//   Parameters:
//     COORD_W  width of each ray origin component
//     DIM_W    width of pixel_x / pixel_y
//     OUT_W    width of each ray direction component
//   Signals:
//     ray_dir_x/y/z  signed ray direction         (master -> slave)
//     ray_org_x/y/z  ray origin (camera position) (master -> slave)
//     pixel_x/y      pixel of the current ray     (master -> slave)
//     ray_valid      ray outputs valid            (master -> slave)
//     ray_ready      consumer accepts the ray     (slave -> master)
//   Modports: master = ray generator, slave = consumer.
interface ray_gen_stream_if #(
  parameter int COORD_W = 11,
  parameter int DIM_W   = 13,
  parameter int OUT_W   = 32
);
  logic [OUT_W-1:0]   ray_dir_x;
  logic [OUT_W-1:0]   ray_dir_y;
  logic [OUT_W-1:0]   ray_dir_z;
  logic [COORD_W-1:0] ray_org_x;
  logic [COORD_W-1:0] ray_org_y;
  logic [COORD_W-1:0] ray_org_z;
  logic [DIM_W-1:0]   pixel_x;
  logic [DIM_W-1:0]   pixel_y;
  logic               ray_valid;
  logic               ray_ready;

  modport master (
    output ray_dir_x, ray_dir_y, ray_dir_z,
    output ray_org_x, ray_org_y, ray_org_z,
    output pixel_x, pixel_y, ray_valid,
    input  ray_ready
  );

  modport slave (
    input  ray_dir_x, ray_dir_y, ray_dir_z,
    input  ray_org_x, ray_org_y, ray_org_z,
    input  pixel_x, pixel_y, ray_valid,
    output ray_ready
  );
endinterface

// File: rtl/ray_gen_stream.sv
// ray_gen_stream
//   Streaming primary-ray generator. Walks the interleaved pixel subset
//   core_id, core_id+S, core_id+2S, ... (S = max(num_cores,1)) using
//   incremental x/y counters and emits one ray per cycle:
//     dir = right*(x - W/2) + up*(H/2 - y) + camera_dir   (mod 2^OUT_W)
//   Ports:
//     clk, reset_n        clock (rising edge), asynchronous active-low reset
//     start, abort        frame start (IDLE only) / frame termination
//     camera_pos_*        camera position, forwarded as ray origin
//     camera_dir/right/up_* signed camera basis
//     image_width/height  W, H
//     core_id, num_cores  first pixel index and index stride (0 -> 1)
//     ray                 ray output stream (ray_gen_stream_if.master)
//     busy                high while a frame is in progress
//     frame_done          one-cycle pulse on completion or rejection
//     cfg_err             sticky rejection flag, cleared by the next start
//   Build option:
//     RAYGEN_CAMERA_LATCH_EN  when defined, camera vectors and image size are
//     captured on the accepted start; otherwise they are used live.
module ray_gen_stream #(
  parameter int COORD_W = 11,
  parameter int DIM_W   = 13,
  parameter int OUT_W   = 32,
  parameter int CORE_W  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] camera_pos_x,
  input  logic [COORD_W-1:0] camera_pos_y,
  input  logic [COORD_W-1:0] camera_pos_z,
  input  logic [COORD_W-1:0] camera_dir_x,
  input  logic [COORD_W-1:0] camera_dir_y,
  input  logic [COORD_W-1:0] camera_dir_z,
  input  logic [COORD_W-1:0] camera_right_x,
  input  logic [COORD_W-1:0] camera_right_y,
  input  logic [COORD_W-1:0] camera_right_z,
  input  logic [COORD_W-1:0] camera_up_x,
  input  logic [COORD_W-1:0] camera_up_y,
  input  logic [COORD_W-1:0] camera_up_z,
  input  logic [DIM_W-1:0]   image_width,
  input  logic [DIM_W-1:0]   image_height,
  input  logic [CORE_W-1:0]  core_id,
  input  logic [CORE_W-1:0]  num_cores,
  ray_gen_stream_if.master   ray,
  output logic               busy,
  output logic               frame_done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  state_t state_reg, state_next;

  // Camera vectors packed as [component] with index 0 = x.
  logic [2:0][COORD_W-1:0] pos_in, dir_in, right_in, up_in;
  logic [2:0][COORD_W-1:0] pos_eff, dir_eff, right_eff, up_eff;
  logic [DIM_W-1:0]        width_eff, height_eff;

  assign pos_in   = {camera_pos_z, camera_pos_y, camera_pos_x};
  assign dir_in   = {camera_dir_z, camera_dir_y, camera_dir_x};
  assign right_in = {camera_right_z, camera_right_y, camera_right_x};
  assign up_in    = {camera_up_z, camera_up_y, camera_up_x};

  // Frame acceptance
  logic [CORE_W-1:0] s_val;
  logic [DIM_W-1:0]  s_ext;
  logic              reject, accept, reject_start;

  assign s_val        = (num_cores == '0) ? CORE_W'(1) : num_cores;
  assign s_ext        = DIM_W'(s_val);
  assign reject       = (image_width == '0) || (image_height == '0) ||
                        (s_ext > image_width) || (core_id >= s_val);
  assign accept       = (state_reg == ST_IDLE) && start && !reject;
  assign reject_start = (state_reg == ST_IDLE) && start && reject;

`ifdef RAYGEN_CAMERA_LATCH_EN
  logic [2:0][COORD_W-1:0] pos_lat_reg, dir_lat_reg, right_lat_reg, up_lat_reg;
  logic [DIM_W-1:0]        width_lat_reg, height_lat_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_lat_reg    <= '0;
      dir_lat_reg    <= '0;
      right_lat_reg  <= '0;
      up_lat_reg     <= '0;
      width_lat_reg  <= '0;
      height_lat_reg <= '0;
    end else if (accept) begin
      pos_lat_reg    <= pos_in;
      dir_lat_reg    <= dir_in;
      right_lat_reg  <= right_in;
      up_lat_reg     <= up_in;
      width_lat_reg  <= image_width;
      height_lat_reg <= image_height;
    end
  end

  assign pos_eff    = pos_lat_reg;
  assign dir_eff    = dir_lat_reg;
  assign right_eff  = right_lat_reg;
  assign up_eff     = up_lat_reg;
  assign width_eff  = width_lat_reg;
  assign height_eff = height_lat_reg;
`else
  assign pos_eff    = pos_in;
  assign dir_eff    = dir_in;
  assign right_eff  = right_in;
  assign up_eff     = up_in;
  assign width_eff  = image_width;
  assign height_eff = image_height;
`endif

  // Pixel counters
  logic [DIM_W-1:0] x_reg, y_reg, stride_reg;
  logic [DIM_W:0]   x_sum, x_sub, y_sum;
  logic [DIM_W-1:0] x_adv;
  logic             wrap, last;

  // S <= W and x < W keep x+S below 2W, so one conditional subtract wraps x.
  assign x_sum = {1'b0, x_reg} + {1'b0, stride_reg};
  assign x_sub = x_sum - {1'b0, width_eff};
  assign wrap  = (x_sum >= {1'b0, width_eff});
  assign x_adv = wrap ? x_sub[DIM_W-1:0] : x_sum[DIM_W-1:0];
  assign y_sum = {1'b0, y_reg} + {{DIM_W{1'b0}}, wrap};
  assign last  = (y_sum == {1'b0, height_eff});

  // Screen-space offsets in DIM_W+1 signed bits, then sign-extended.
  logic signed [DIM_W:0]   off_x, off_y;
  logic signed [OUT_W-1:0] off_x_w, off_y_w;

  assign off_x   = $signed({1'b0, x_reg}) - $signed({2'b00, width_eff[DIM_W-1:1]});
  assign off_y   = $signed({2'b00, height_eff[DIM_W-1:1]}) - $signed({1'b0, y_reg});
  assign off_x_w = {{(OUT_W-DIM_W-1){off_x[DIM_W]}}, off_x};
  assign off_y_w = {{(OUT_W-DIM_W-1){off_y[DIM_W]}}, off_y};

  logic [2:0][OUT_W-1:0] dir_calc;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_comp
      logic signed [OUT_W-1:0] r_ext, u_ext, d_ext;
      assign r_ext = {{(OUT_W-COORD_W){right_eff[gi][COORD_W-1]}}, right_eff[gi]};
      assign u_ext = {{(OUT_W-COORD_W){up_eff[gi][COORD_W-1]}}, up_eff[gi]};
      assign d_ext = {{(OUT_W-COORD_W){dir_eff[gi][COORD_W-1]}}, dir_eff[gi]};
      // Products are kept at OUT_W: the result wraps modulo 2^OUT_W.
      assign dir_calc[gi] = r_ext * off_x_w + u_ext * off_y_w + d_ext;
    end
  endgenerate

  // Output register
  logic [2:0][OUT_W-1:0]   dir_reg;
  logic [2:0][COORD_W-1:0] org_reg;
  logic [DIM_W-1:0]        pix_x_reg, pix_y_reg;
  logic                    valid_reg, frame_done_reg, cfg_err_reg;
  logic                    load_en, finish_en;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN: begin
        if (abort)               state_next = ST_IDLE;
        else if (load_en && last) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (abort)          state_next = ST_IDLE;
        else if (finish_en) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_reg != ST_IDLE);
    load_en   = 1'b0;
    finish_en = 1'b0;
    case (state_reg)
      ST_RUN:  load_en   = !abort && (!valid_reg || ray.ray_ready);
      ST_DONE: finish_en = !abort && valid_reg && ray.ray_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg          <= '0;
      y_reg          <= '0;
      stride_reg     <= '0;
      dir_reg        <= '0;
      org_reg        <= '0;
      pix_x_reg      <= '0;
      pix_y_reg      <= '0;
      valid_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      frame_done_reg <= reject_start || finish_en;
      if ((state_reg == ST_IDLE) && start) cfg_err_reg <= reject;

      if (accept) begin
        x_reg      <= DIM_W'(core_id);
        y_reg      <= '0;
        stride_reg <= s_ext;
      end else if (load_en) begin
        x_reg <= x_adv;
        y_reg <= y_sum[DIM_W-1:0];
      end

      // Abort drops any pending ray.
      if (busy && abort) begin
        valid_reg <= 1'b0;
      end else if (load_en) begin
        valid_reg <= 1'b1;
        dir_reg   <= dir_calc;
        org_reg   <= pos_eff;
        pix_x_reg <= x_reg;
        pix_y_reg <= y_reg;
      end else if (valid_reg && ray.ray_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign ray.ray_dir_x = dir_reg[0];
  assign ray.ray_dir_y = dir_reg[1];
  assign ray.ray_dir_z = dir_reg[2];
  assign ray.ray_org_x = org_reg[0];
  assign ray.ray_org_y = org_reg[1];
  assign ray.ray_org_z = org_reg[2];
  assign ray.pixel_x   = pix_x_reg;
  assign ray.pixel_y   = pix_y_reg;
  assign ray.ray_valid = valid_reg;
  assign frame_done    = frame_done_reg;
  assign cfg_err       = cfg_err_reg;

endmodule

// File: doc/ray_gen_stream.md
# ray_gen_stream

Parametrised, streaming successor to the per-core primary-ray generator. It walks an interleaved subset of image pixels (pixel index = core_id + k·num_cores) using incremental x/y counters rather than divide/modulo. For each pixel it computes the unnormalised ray direction right·(x − W/2) + up·(H/2 − y) + dir. It sits between the camera-configuration registers and a traversal core, and delivers one ray per cycle over a valid/ready handshake.

## Interface
- COORD_W, 11, width of each signed two's-complement camera vector component
- DIM_W, 13, width of the unsigned image_width/image_height inputs and of pixel_x/pixel_y
- OUT_W, 32, width of each signed ray component
- CORE_W, 3, width of core_id and num_cores
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start; sampled in IDLE only
- abort  in  1  terminate frame immediately; no frame_done
- camera_pos_x/y/z  in  COORD_W each  camera position; forwarded unchanged on ray_org_x/y/z
- camera_dir_x/y/z, camera_right_x/y/z, camera_up_x/y/z  in  COORD_W each  signed camera basis
- image_width, image_height  in  DIM_W  W, H
- core_id  in  CORE_W  first pixel index for this core
- num_cores  in  CORE_W  index stride; 0 is treated as 1
- ray_dir_x/y/z  out  OUT_W each  signed ray direction
- ray_org_x/y/z  out  COORD_W each  ray origin
- pixel_x, pixel_y  out  DIM_W  pixel of the current ray
- ray_valid  out  1  ray outputs valid
- ray_ready  in  1  consumer accepts; a transfer occurs when ray_valid && ray_ready
- busy  out  1  high from RUN entry until return to IDLE
- frame_done  out  1  one-cycle pulse at normal frame completion
- cfg_err  out  1  sticky until next start; set when a frame is rejected

## Operation
- States: IDLE, RUN, DONE.
- IDLE + start:
  - Compute S = max(num_cores, 1).
  - Reject the frame if W==0, H==0, S>W, or core_id>=S. On rejection: cfg_err=1, frame_done pulses, stay IDLE.
  - Otherwise load x=core_id, y=0 and enter RUN.
- RUN, ray generation: when the output register is empty or being transferred this cycle, register the ray for (x, y), set ray_valid=1, then advance:
  - x' = x + S
  - if x' >= W: x' = x' − W, y' = y + 1
- RUN, end of frame: if the advance makes y' == H, no further rays are generated. The state moves to DONE once that last ray is loaded.
- DONE: hold until the final ray transfers. Then clear ray_valid, pulse frame_done, go IDLE.
- Arithmetic: all camera operands are sign-extended to OUT_W. Offsets are computed as (x − (W>>1)) and ((H>>1) − y) in signed DIM_W+1 bits. Results wrap modulo 2^OUT_W, with no saturation.
- Backpressure: while ray_valid && !ray_ready, every ray output and pixel_x/pixel_y hold stable and the counters do not advance.
- Ignored inputs: start while busy is ignored; start and abort in the same IDLE cycle are treated as start only.
- abort while busy: next cycle ray_valid=0 and the state is IDLE, with no frame_done. A pending ray is dropped.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset asserted mid-frame: everything clears asynchronously; the frame is not resumed.

## Timing
- start sampled at edge T → busy=1 after T+1, first ray_valid after T+2.
- Sustained throughput is one ray per cycle while ray_ready is high.
- Last-ray transfer at edge E → frame_done high for the cycle after E, busy low from E+1.
- Rejected start at edge T → frame_done and cfg_err high after T+1; busy stays 0.
- Rays per frame = ceil((W·H − core_id)/S).

## Configuration
- RAYGEN_CAMERA_LATCH_EN defined: camera_*, image_width and image_height are captured into internal registers on the accepted start. Input changes mid-frame have no effect on the frame.
- Not defined: these inputs are used live every cycle. The software layer must hold them stable while busy. ray_org reflects the live camera_pos.

## Test plan
- Full frame, single core:
  - Stimulus: W=4, H=2, S=1, core_id=0, right=(1,0,0), up=(0,1,0), dir=(0,0,5), ready=1.
  - Expected: 8 rays on consecutive cycles; first ray (−2,1,5) at pixel (0,0); last ray (1,0,5) at pixel (3,1); frame_done one cycle after the last transfer.
- Interleaved: W=4, H=2, num_cores=3, core_id=2 → exactly 2 rays, at pixel (2,0) then (1,1), then frame_done.
- Negative wrap: right_x=11'h7FF (−1), W=4, pixel (0,0) → ray_dir_x=2. With dir_x=11'h400 (−1024) plus right term → correct 32-bit signed value.
- Backpressure: ray_ready low for 3 cycles mid-frame → outputs and pixel held; no ray lost or duplicated; total count still 8.
- Rejection and abort:
  - num_cores=5, W=4 → cfg_err=1, frame_done pulse, 0 rays.
  - abort after the 3rd ray → ray_valid=0 next cycle, no frame_done, next start runs normally.
- Reset during RUN: reset_n low for 1 cycle → all outputs 0 immediately; a fresh start reproduces the full-frame sequence.
